regfile_2r1w: RTL

//  General-purpose register file for the single-cycle MIPS datapath.

---
 rtl/regfile_2r1w.sv | 62 ++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write MIPS register file, $0 hardwired to zero
// Defining REGFILE_BYPASS_EN forwards a same-cycle write onto every read port.
module regfile_2r1w #(
  parameter int N = 32,
  parameter int REGS = 32,
  localparam int AW = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic [AW-1:0] dbg_ra,
  output logic [N-1:0]  dbg_rd
);

  if (REGS < 2 || (REGS & (REGS - 1)) != 0) begin : g_bad_regs
    $error("regfile_2r1w: REGS must be a power of two and >= 2");
  end

  // Entry 0 has no storage; the read logic supplies its zero.
  logic [N-1:0] mem [1:REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we3 && wa3 != '0) begin
      mem[wa3] <= wd3;
    end
  end

  function automatic logic [N-1:0] read_port(input logic [AW-1:0] addr);
    logic [N-1:0] val;
    val = '0;
    if (addr != '0) begin
      val = mem[addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 != '0 && addr == wa3) begin
      val = wd3;
    end
`endif
    // Outputs read as zero for the whole time reset is held.
    if (!rst_n) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd1    = read_port(ra1);
    rd2    = read_port(ra2);
    dbg_rd = read_port(dbg_ra);
  end

endmodule
